// File: rtl/ghash_accumulator_fsm_if.sv
// ghash_accumulator_fsm_if
//   Block-stream and tag handshake bundle for the GHASH accumulator.
//   master : block/key producer and tag consumer (drives blocks, key, tag_ready)
//   slave  : the accumulator (drives ready, tag, tag_valid, err)
//   Signals:
//     h_key     NB_DATA  hash subkey H
//     h_load    1        load h_key into the H register (IDLE only)
//     data      NB_DATA  input block X_i
//     valid     1        data valid
//     sop/eop   1        first/last block of a message, qualified by valid
//     ready     1        block accepted when valid & ready
//     tag       NB_DATA  GHASH result
//     tag_valid 1        tag valid, held until tag_ready
//     tag_ready 1        tag consumer ready
//     err       1        one-cycle pulse on protocol violation
interface ghash_accumulator_fsm_if #(
    parameter int NB_DATA = 128
);
    logic [NB_DATA-1:0] h_key;
    logic               h_load;
    logic [NB_DATA-1:0] data;
    logic               valid;
    logic               sop;
    logic               eop;
    logic               ready;
    logic [NB_DATA-1:0] tag;
    logic               tag_valid;
    logic               tag_ready;
    logic               err;

    modport master (
        output h_key, h_load, data, valid, sop, eop, tag_ready,
        input  ready, tag, tag_valid, err
    );

    modport slave (
        input  h_key, h_load, data, valid, sop, eop, tag_ready,
        output ready, tag, tag_valid, err
    );
endinterface

// File: rtl/ghash_accumulator_fsm.sv
// ghash_accumulator_fsm
//   GHASH accumulation stage: Y_i = (Y_{i-1} ^ X_i) * H in GF(2^128), one block per
//   clock. The multiplier is combinational; its product is registered into the
//   accumulator on acceptance. The last block's product is presented as the tag on a
//   valid/ready handshake.
//   Ports:
//     i_clock  clock
//     i_reset  synchronous, active-high reset (clears H as well)
//     bus      ghash_accumulator_fsm_if.slave (block stream, key load, tag handshake)
module ghash_accumulator_fsm #(
    parameter int NB_DATA = 128
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    ghash_accumulator_fsm_if.slave  bus
);

    if (NB_DATA != 128) begin : g_bad_conf
        $error("BAD_CONF: NB_DATA must be 128");
    end

    // GCM bit order: bit NB_DATA-1 holds the x^0 coefficient, so multiplying by x is a
    // right shift and the reduction polynomial folds back in at the top byte.
    localparam logic [NB_DATA-1:0] RED = {8'he1, {(NB_DATA-8){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [NB_DATA-1:0] h_q;
    logic [NB_DATA-1:0] acc_q;
    logic [NB_DATA-1:0] tag_q;
    logic               err_q;

    logic               ready;
    logic               tag_valid;
    logic               accept;
    logic               take;
    logic               load_now;
    logic               proto_err;
    logic [NB_DATA-1:0] acc_sel;
    logic [NB_DATA-1:0] h_sel;
    logic [NB_DATA-1:0] product;

    function automatic logic [NB_DATA-1:0] gf128_mul(input logic [NB_DATA-1:0] x,
                                                      input logic [NB_DATA-1:0] y);
        logic [NB_DATA-1:0] z;
        logic [NB_DATA-1:0] v;
        z = '0;
        v = y;
        // Walk x from its x^0 coefficient upward, keeping v = y * x^i.
        for (int i = NB_DATA - 1; i >= 0; i--) begin
            if (x[i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ RED) : (v >> 1);
        end
        return z;
    endfunction

    assign accept    = bus.valid & ready;
    // A sop block always starts a fresh message; a non-sop block only counts in RUN.
    assign take      = accept & ((state_q == RUN) | bus.sop);
    assign load_now  = (state_q == IDLE) & bus.h_load;
    assign proto_err = accept & (((state_q == IDLE) & ~bus.sop) |
                                 ((state_q == RUN)  &  bus.sop));
    assign acc_sel   = bus.sop ? '0 : acc_q;
    // A key loaded alongside the first block must already apply to that block.
    assign h_sel     = load_now ? bus.h_key : h_q;
    assign product   = gf128_mul(acc_sel ^ bus.data, h_sel);

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = bus.eop ? DONE : RUN;
            RUN:     if (take && bus.eop) state_d = DONE;
            DONE:    if (bus.tag_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        ready     = (state_q != DONE);
        tag_valid = (state_q == DONE);
    end

    // Datapath registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            h_q   <= '0;
            acc_q <= '0;
            tag_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (load_now)      h_q   <= bus.h_key;
            if (take)          acc_q <= product;
            if (take & bus.eop) tag_q <= product;
            err_q <= proto_err;
        end
    end

    assign bus.ready     = ready;
    assign bus.tag_valid = tag_valid;
    assign bus.tag       = tag_q;
    assign bus.err       = err_q;

endmodule
